// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in Execute.
// Special cases (divide-by-zero, signed overflow) complete in the issue cycle; others take XLEN+2 cycles.
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   input  logic            kill_i,
   input  logic            hold_i,
   output logic            stall_req_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_quot;
   logic [XLEN-1:0]   r_div;
   logic [XLEN-1:0]   r_result;
   logic              r_rem_op;
   logic              r_neg_q;
   logic              r_neg_r;

   logic              w_signed_op;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [XLEN-1:0]   w_abs_a;
   logic [XLEN-1:0]   w_abs_b;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;
   logic              w_ge;
   logic [XLEN-1:0]   w_rem_nx;
   logic [XLEN-1:0]   w_quot_nx;
   logic [XLEN-1:0]   w_final;

   // Issue-cycle decode: op_i[0]=0 is a signed op, op_i[1]=1 selects the remainder.
   assign w_signed_op = ~op_i[0];
   assign w_div0      = (operand_b_i == '0);
   assign w_ovf       = w_signed_op
                        && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (operand_b_i == '1);
   assign w_special   = w_div0 | w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_div0) begin
         w_special_res = op_i[1] ? operand_a_i : '1;
      end else begin
         w_special_res = op_i[1] ? '0 : operand_a_i;
      end
   end

   assign w_abs_a = (w_signed_op && operand_a_i[XLEN-1]) ? (~operand_a_i + 1'b1) : operand_a_i;
   assign w_abs_b = (w_signed_op && operand_b_i[XLEN-1]) ? (~operand_b_i + 1'b1) : operand_b_i;

   // One restoring step; the extra top bit makes the compare a plain borrow check.
   assign w_shift   = {r_rem, r_quot[XLEN-1]};
   assign w_diff    = w_shift - {1'b0, r_div};
   assign w_ge      = ~w_diff[XLEN];
   assign w_rem_nx  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
   assign w_quot_nx = {r_quot[XLEN-2:0], w_ge};

   always_comb begin
      w_final = '0;
      if (r_rem_op) begin
         w_final = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
      end else begin
         w_final = r_neg_q ? (~w_quot_nx + 1'b1) : w_quot_nx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quot   <= '0;
         r_div    <= '0;
         r_result <= '0;
         r_rem_op <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!kill_i && start_i && !w_special) begin
                  r_quot   <= w_abs_a;
                  r_div    <= w_abs_b;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_rem_op <= op_i[1];
                  r_neg_q  <= w_signed_op & (operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1]);
                  r_neg_r  <= w_signed_op & operand_a_i[XLEN-1];
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (kill_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem  <= w_rem_nx;
                  r_quot <= w_quot_nx;
                  r_cnt  <= r_cnt + 1'b1;
                  // Sign correction is folded into the last iteration so DONE drives a plain register.
                  if (r_cnt == CNT_W'(XLEN - 1)) begin
                     r_result <= w_final;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (kill_i || !hold_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      stall_req_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      result_o    = '0;
      case (r_state)
         S_IDLE: begin
            if (!kill_i && start_i) begin
               if (w_special) begin
                  done_o   = 1'b1;
                  result_o = w_special_res;
               end else begin
                  stall_req_o = 1'b1;
               end
            end
         end
         S_BUSY: begin
            busy_o      = 1'b1;
            stall_req_o = ~kill_i;
         end
         S_DONE: begin
            busy_o = 1'b1;
            if (!kill_i) begin
               done_o   = 1'b1;
               result_o = r_result;
            end
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences and random ops vs. an arithmetic model.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        hold;
   logic        stall_req;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

   div_unit #(.XLEN(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .op_i        (op),
      .operand_a_i (a),
      .operand_b_i (b),
      .kill_i      (kill),
      .hold_i      (hold),
      .stall_req_o (stall_req),
      .busy_o      (busy),
      .done_o      (done),
      .result_o    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          exp_cyc;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RV32M semantics straight from the ISA rules.
   function automatic logic [31:0] ref_div(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = ra;
      sb = rb;
      if (rb == 32'd0) return rop[1] ? ra : 32'hFFFF_FFFF;
      if (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) return rop[1] ? 32'd0 : 32'h8000_0000;
      if (!rop[0]) return rop[1] ? 32'(sa % sb) : 32'(sa / sb);
      return rop[1] ? (ra % rb) : (ra / rb);
   endfunction

   function automatic int ref_cyc(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb);
      if (rb == 32'd0) return 1;
      if (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issue an op and hold start until done_o; reports result, residency and stall cycles.
   task automatic run_op(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] res, output int cyc, output int stalls);
      logic got;
      got = 1'b0;
      cyc = 0;
      stalls = 0;
      res = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b1;
      op = iop;
      a = ia;
      b = ib;
      while (!got && cyc < 100) begin
         #1;
         cyc++;
         if (stall_req) stalls++;
         if (done) begin
            got = 1'b1;
            res = result;
         end else begin
            @(negedge clk);
         end
      end
      check("op_timeout", {31'd0, got}, 32'd1);
      @(negedge clk);
      start = 1'b0;
   endtask

   vec_t        tbl[14];
   logic [31:0] res;
   int          cyc;
   int          stalls;
   int          busy_n;
   logic [1:0]  rop;
   logic [31:0] ra;
   logic [31:0] rb;
   int          sel;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op = 2'b00;
      a = '0;
      b = '0;
      kill = 1'b0;
      hold = 1'b0;

      tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
      tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
      tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
      tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
      tbl[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
      tbl[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      tbl[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
      tbl[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      tbl[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      tbl[9]  = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
      tbl[10] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
      tbl[11] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
      tbl[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
      tbl[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};

      // Reset state
      @(negedge clk);
      #1;
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, cyc, stalls);
         check($sformatf("vec%0d_result", i), res, tbl[i].exp);
         check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
         check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(tbl[i].exp_cyc - 1));
      end

      // Kill on the 10th BUSY cycle, then a fresh op must still complete
      @(negedge clk);
      start = 1'b1;
      op = 2'b01;
      a = 32'd1000;
      b = 32'd3;
      busy_n = 0;
      cyc = 0;
      while (busy_n < 10 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_n++;
      end
      check("kill_reach_busy10", 32'(busy_n), 32'd10);
      kill = 1'b1;
      start = 1'b0;
      #1;
      check("kill_cycle_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      kill = 1'b0;
      #1;
      check("kill_next_stall", {31'd0, stall_req}, 32'd0);
      check("kill_next_busy", {31'd0, busy}, 32'd0);
      check("kill_next_done", {31'd0, done}, 32'd0);
      run_op(2'b01, 32'd9, 32'd3, res, cyc, stalls);
      check("after_kill_result", res, 32'd3);
      check("after_kill_cycles", 32'(cyc), 32'd34);

      // Kill in IDLE suppresses even a same-cycle special result
      @(negedge clk);
      kill = 1'b1;
      start = 1'b1;
      op = 2'b01;
      a = 32'd5;
      b = 32'd0;
      #1;
      check("idle_kill_done", {31'd0, done}, 32'd0);
      check("idle_kill_result", result, 32'd0);
      @(negedge clk);
      kill = 1'b0;
      start = 1'b0;
      #1;
      check("idle_kill_busy", {31'd0, busy}, 32'd0);

      // hold_i in DONE for 3 cycles: done_o/result stable for 4 cycles, no restart
      @(negedge clk);
      start = 1'b1;
      op = 2'b01;
      a = 32'd100;
      b = 32'd7;
      cyc = 0;
      #1;
      while (!done && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("hold_reach_done", {31'd0, done}, 32'd1);
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (i == 3) hold = 1'b0;
            #1;
         end
         check($sformatf("hold%0d_done", i), {31'd0, done}, 32'd1);
         check($sformatf("hold%0d_result", i), result, 32'd14);
         check($sformatf("hold%0d_stall", i), {31'd0, stall_req}, 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      check("hold_release_done", {31'd0, done}, 32'd0);
      check("hold_release_busy", {31'd0, busy}, 32'd0);
      check("hold_release_result", result, 32'd0);

      // Asynchronous reset mid-operation discards the work
      @(negedge clk);
      start = 1'b1;
      op = 2'b01;
      a = 32'd50;
      b = 32'd5;
      repeat (5) @(negedge clk);
      #1;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_stall", {31'd0, stall_req}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b01, 32'd50, 32'd5, res, cyc, stalls);
      check("midrst_after_result", res, 32'd10);

      // Random ops against the arithmetic model
      for (int n = 0; n < 150; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            3: begin
               ra = 32'h8000_0000;
               rb = 32'hFFFF_FFFF;
            end
            4: begin
               ra = 32'($urandom_range(0, 1000));
               rb = $urandom;
            end
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         run_op(rop, ra, rb, res, cyc, stalls);
         check($sformatf("rnd%0d_op%0d_%h_%h_result", n, rop, ra, rb), res, ref_div(rop, ra, rb));
         check($sformatf("rnd%0d_cycles", n), 32'(cyc), 32'(ref_cyc(rop, ra, rb)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
